// File: rtl/bus_hand_pkg.sv
// Shared handshake definitions for the 4-bit master/slave data path.
package bus_hand_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/bus_sat_cnt.sv
// Saturating event counter with a sticky "any event seen" flag and a
// synchronous clear that wins over a same-cycle increment.
module bus_sat_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sticky
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;

  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (clr) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (inc) begin
      if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign cnt    = cnt_q;
  assign sticky = sticky_q;

endmodule

// File: rtl/data_slave_packer.sv
// Packs BEATS single-cycle beats from a non-stalling master into one wide
// word on a valid/ready port; beats arriving while not ready are counted.
module data_slave_packer
  import bus_hand_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned BEATS = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid,
  input  logic [WIDTH-1:0]       data,
  output logic                   ready,
  output logic [WIDTH*BEATS-1:0] word_out,
  output logic                   word_valid,
  input  logic                   word_ready,
  input  logic                   clr_stat,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   overflow
);

  localparam int unsigned WORD_W = WIDTH * BEATS;
  localparam int unsigned BCNT_W = $clog2(BEATS);
  localparam int unsigned LAST   = BEATS - 1;

  state_e                         state_q, state_d;
  logic [BCNT_W-1:0]              beat_cnt_q, beat_cnt_d;
  logic [BEATS-1:0][WIDTH-1:0]    pack_q, pack_d;
  logic [BEATS-1:0][WIDTH-1:0]    completed;
  logic [WORD_W-1:0]              word_out_q, word_out_d;
  logic                           word_valid_q, word_valid_d;
  logic                           accept;
  logic                           drop;

  // ready is a pure state decode so the master never sees an input-to-ready path
  assign ready  = (state_q == ST_COLLECT);
  assign accept = valid & ready;
  assign drop   = valid & ~ready;

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    pack_d       = pack_q;
    word_out_d   = word_out_q;
    word_valid_d = word_valid_q;
    completed    = pack_q;
    completed[LAST] = data;

    unique case (state_q)
      ST_COLLECT: begin
        if (word_valid_q && word_ready) word_valid_d = 1'b0;
        if (accept) begin
          if (beat_cnt_q != BCNT_W'(LAST)) begin
            pack_d[beat_cnt_q] = data;
            beat_cnt_d         = beat_cnt_q + BCNT_W'(1);
          end else begin
            beat_cnt_d = '0;
            if (!word_valid_q || word_ready) begin
              word_out_d   = completed;
              word_valid_d = 1'b1;
            end else begin
              // Output slot busy: park the finished word in pack until drained
              pack_d[LAST] = data;
              state_d      = ST_HOLD;
            end
          end
        end
      end
      ST_HOLD: begin
        if (word_ready) begin
          word_out_d   = pack_q;
          word_valid_d = 1'b1;
          state_d      = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_COLLECT;
      beat_cnt_q   <= '0;
      pack_q       <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      pack_q       <= pack_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;

  bus_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_drop_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr_stat),
    .inc    (drop),
    .cnt    (drop_cnt),
    .sticky (overflow)
  );

endmodule

// File: tb/tb_data_slave_packer.sv
// Directed bench for data_slave_packer (WIDTH=4, BEATS=4, CNT_W=2).
module tb_data_slave_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [3:0]  data;
  logic        ready;
  logic [15:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic        clr_stat;
  logic [1:0]  drop_cnt;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_slave_packer #(
    .WIDTH (4),
    .BEATS (4),
    .CNT_W (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      (valid),
    .data       (data),
    .ready      (ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .clr_stat   (clr_stat),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow)
  );

  // One clock with the given beat presented; returns #1 after the edge.
  task automatic cyc(input logic v, input logic [3:0] d);
    valid = v;
    data  = d;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; valid = 1'b0; data = '0; word_ready = 1'b0; clr_stat = 1'b0;
    #2;
    n_checks++;
    if ({ready, word_valid, word_out, drop_cnt, overflow} !== {1'b1, 1'b0, 16'h0, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_during: got rdy=%b wv=%b wo=%h dc=%0d ov=%b expected rdy=1 wv=0 wo=0000 dc=0 ov=0",
               ready, word_valid, word_out, drop_cnt, overflow);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({ready, word_valid, word_out} !== {1'b1, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_after: got rdy=%b wv=%b wo=%h expected rdy=1 wv=0 wo=0000", ready, word_valid, word_out);
    end
  endtask

  task automatic test_contiguous;
    word_ready = 1'b1;
    cyc(1'b1, 4'h1); cyc(1'b1, 4'h2); cyc(1'b1, 4'h3);
    n_checks++;
    if (word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL contig_early: got wv=%b expected 0", word_valid);
    end
    cyc(1'b1, 4'h4);
    n_checks++;
    if ({word_valid, word_out} !== {1'b1, 16'h4321}) begin
      n_fail++;
      $display("FAIL contig_word: got wv=%b wo=%h expected wv=1 wo=4321", word_valid, word_out);
    end
    cyc(1'b0, 4'h0);
    n_checks++;
    if ({word_valid, drop_cnt} !== {1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL contig_drain: got wv=%b dc=%0d expected wv=0 dc=0", word_valid, drop_cnt);
    end
  endtask

  task automatic test_gaps;
    word_ready = 1'b1;
    cyc(1'b1, 4'hA); cyc(1'b0, 4'h0); cyc(1'b0, 4'h0); cyc(1'b0, 4'h0);
    cyc(1'b1, 4'hB); cyc(1'b1, 4'hC); cyc(1'b0, 4'h0); cyc(1'b1, 4'hD);
    n_checks++;
    if ({word_valid, word_out} !== {1'b1, 16'hDCBA}) begin
      n_fail++;
      $display("FAIL gaps_word: got wv=%b wo=%h expected wv=1 wo=dcba", word_valid, word_out);
    end
    cyc(1'b0, 4'h0);
  endtask

  task automatic test_backpressure;
    word_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'(i));
    n_checks++;
    if ({ready, word_valid, word_out} !== {1'b1, 1'b1, 16'h3210}) begin
      n_fail++;
      $display("FAIL bp_first: got rdy=%b wv=%b wo=%h expected rdy=1 wv=1 wo=3210", ready, word_valid, word_out);
    end
    for (int i = 4; i < 8; i++) cyc(1'b1, 4'(i));
    n_checks++;
    if ({ready, word_valid, word_out} !== {1'b0, 1'b1, 16'h3210}) begin
      n_fail++;
      $display("FAIL bp_hold: got rdy=%b wv=%b wo=%h expected rdy=0 wv=1 wo=3210", ready, word_valid, word_out);
    end
    cyc(1'b1, 4'h8);
    n_checks++;
    if ({ready, drop_cnt, overflow} !== {1'b0, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_drop: got rdy=%b dc=%0d ov=%b expected rdy=0 dc=1 ov=1", ready, drop_cnt, overflow);
    end
    word_ready = 1'b1;
    cyc(1'b0, 4'h0);
    word_ready = 1'b0;
    n_checks++;
    if ({ready, word_valid, word_out} !== {1'b1, 1'b1, 16'h7654}) begin
      n_fail++;
      $display("FAIL bp_second: got rdy=%b wv=%b wo=%h expected rdy=1 wv=1 wo=7654", ready, word_valid, word_out);
    end
    cyc(1'b0, 4'h0);
    n_checks++;
    if ({word_valid, word_out} !== {1'b1, 16'h7654}) begin
      n_fail++;
      $display("FAIL bp_stable: got wv=%b wo=%h expected wv=1 wo=7654", word_valid, word_out);
    end
    word_ready = 1'b1;
    cyc(1'b0, 4'h0);
    n_checks++;
    if (word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got wv=%b expected 0", word_valid);
    end
    clr_stat = 1'b1;
    cyc(1'b0, 4'h0);
    clr_stat = 1'b0;
    n_checks++;
    if ({drop_cnt, overflow} !== {2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_clear: got dc=%0d ov=%b expected dc=0 ov=0", drop_cnt, overflow);
    end
  endtask

  task automatic test_back_to_back;
    logic rdy_all;
    rdy_all = 1'b1;
    word_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 4'(i));
      rdy_all = rdy_all & ready;
    end
    word_ready = 1'b1;
    cyc(1'b1, 4'h7);
    rdy_all = rdy_all & ready;
    n_checks++;
    if ({ready, word_valid, word_out} !== {1'b1, 1'b1, 16'h7654}) begin
      n_fail++;
      $display("FAIL b2b_word: got rdy=%b wv=%b wo=%h expected rdy=1 wv=1 wo=7654", ready, word_valid, word_out);
    end
    n_checks++;
    if (rdy_all !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_nohold: got ready_all=%b expected 1", rdy_all);
    end
    cyc(1'b0, 4'h0);
    word_ready = 1'b0;
    n_checks++;
    if ({word_valid, drop_cnt} !== {1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL b2b_drain: got wv=%b dc=%0d expected wv=0 dc=0", word_valid, drop_cnt);
    end
  endtask

  task automatic test_saturation;
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) cyc(1'b1, 4'(i));
    cyc(1'b1, 4'hF); cyc(1'b1, 4'hF);
    n_checks++;
    if ({drop_cnt, overflow} !== {2'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL sat_two: got dc=%0d ov=%b expected dc=2 ov=1", drop_cnt, overflow);
    end
    cyc(1'b1, 4'hF); cyc(1'b1, 4'hF); cyc(1'b1, 4'hF);
    n_checks++;
    if ({drop_cnt, overflow} !== {2'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL sat_five: got dc=%0d ov=%b expected dc=3 ov=1", drop_cnt, overflow);
    end
    clr_stat = 1'b1;
    cyc(1'b1, 4'hF);
    clr_stat = 1'b0;
    n_checks++;
    if ({drop_cnt, overflow} !== {2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL sat_clear: got dc=%0d ov=%b expected dc=0 ov=0", drop_cnt, overflow);
    end
    word_ready = 1'b1;
    cyc(1'b0, 4'h0);
    word_ready = 1'b0;
    cyc(1'b1, 4'h9);
    n_checks++;
    if ({ready, word_out, drop_cnt} !== {1'b1, 16'h7654, 2'd0}) begin
      n_fail++;
      $display("FAIL sat_exit: got rdy=%b wo=%h dc=%0d expected rdy=1 wo=7654 dc=0", ready, word_out, drop_cnt);
    end
  endtask

  task automatic test_reset_mid;
    word_ready = 1'b1;
    cyc(1'b1, 4'h1); cyc(1'b1, 4'h2);
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({ready, word_valid, word_out} !== {1'b1, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL rst_mid_word: got rdy=%b wv=%b wo=%h expected rdy=1 wv=0 wo=0000", ready, word_valid, word_out);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    cyc(1'b1, 4'h5); cyc(1'b1, 4'h6); cyc(1'b1, 4'h7); cyc(1'b1, 4'h8);
    n_checks++;
    if ({word_valid, word_out} !== {1'b1, 16'h8765}) begin
      n_fail++;
      $display("FAIL rst_word: got wv=%b wo=%h expected wv=1 wo=8765", word_valid, word_out);
    end
    cyc(1'b0, 4'h0);
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) cyc(1'b1, 4'(i + 8));
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_hold_pre: got rdy=%b expected 0", ready);
    end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({ready, word_valid, word_out} !== {1'b1, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL rst_mid_hold: got rdy=%b wv=%b wo=%h expected rdy=1 wv=0 wo=0000", ready, word_valid, word_out);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    word_ready = 1'b1;
    cyc(1'b1, 4'h1); cyc(1'b1, 4'h2); cyc(1'b1, 4'h3); cyc(1'b1, 4'h4);
    n_checks++;
    if ({word_valid, word_out} !== {1'b1, 16'h4321}) begin
      n_fail++;
      $display("FAIL rst_hold_post: got wv=%b wo=%h expected wv=1 wo=4321", word_valid, word_out);
    end
  endtask

  initial begin
    test_reset();
    test_contiguous();
    test_gaps();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
